// File: rtl/dp_sram_be_if.sv
// rtl/dp_sram_be_if.sv - dual-port SRAM request/response bundle for ports A and B
interface dp_sram_be_if #(
   parameter int SRAM_DEPTH = 16,
   parameter int DATA_WIDTH = 32
);
   localparam int ADDR_WIDTH = (SRAM_DEPTH > 2) ? $clog2(SRAM_DEPTH) : 1;
   localparam int NBYTE      = DATA_WIDTH / 8;

   logic                  iCsnA;
   logic                  iWrnA;
   logic [ADDR_WIDTH-1:0] iAddrA;
   logic [DATA_WIDTH-1:0] iWrDtA;
   logic [NBYTE-1:0]      iBeA;
   logic [DATA_WIDTH-1:0] oRdDtA;
   logic                  oRdVldA;

   logic                  iCsnB;
   logic                  iWrnB;
   logic [ADDR_WIDTH-1:0] iAddrB;
   logic [DATA_WIDTH-1:0] iWrDtB;
   logic [NBYTE-1:0]      iBeB;
   logic [DATA_WIDTH-1:0] oRdDtB;
   logic                  oRdVldB;

   logic                  oBusy;
   logic [1:0]            oAddrErr;

   modport master (
      output iCsnA, iWrnA, iAddrA, iWrDtA, iBeA,
      output iCsnB, iWrnB, iAddrB, iWrDtB, iBeB,
      input  oRdDtA, oRdVldA, oRdDtB, oRdVldB, oBusy, oAddrErr
   );

   modport slave (
      input  iCsnA, iWrnA, iAddrA, iWrDtA, iBeA,
      input  iCsnB, iWrnB, iAddrB, iWrDtB, iBeB,
      output oRdDtA, oRdVldA, oRdDtB, oRdVldB, oBusy, oAddrErr
   );
endinterface

// File: rtl/dp_sram_be.sv
// rtl/dp_sram_be.sv - dual-port byte-enable SRAM with zeroing init sweep
module dp_sram_be #(
   parameter int SRAM_DEPTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic        iClk,
   input  logic        iRst,
   dp_sram_be_if.slave bus
);
   localparam int ADDR_WIDTH = (SRAM_DEPTH > 2) ? $clog2(SRAM_DEPTH) : 1;
   localparam int NBYTE      = DATA_WIDTH / 8;

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_mem [SRAM_DEPTH];

   logic                  r_vld1_a, r_vld1_b;
   logic [DATA_WIDTH-1:0] r_dt1_a, r_dt1_b;
   logic [1:0]            r_err;

   logic                  w_ready;
   logic                  w_a_req, w_b_req;
   logic                  w_a_in, w_b_in;
   logic                  w_a_rd, w_b_rd;
   logic                  w_a_wr, w_b_wr;
   logic [DATA_WIDTH-1:0] w_a_rdata, w_b_rdata;

   // Requests count only in READY and never on a reset edge
   assign w_ready   = (r_state == S_READY) && !iRst;
   assign w_a_req   = w_ready && !bus.iCsnA;
   assign w_b_req   = w_ready && !bus.iCsnB;
   assign w_a_in    = 32'(bus.iAddrA) < 32'(SRAM_DEPTH);
   assign w_b_in    = 32'(bus.iAddrB) < 32'(SRAM_DEPTH);
   assign w_a_rd    = w_a_req && bus.iWrnA;
   assign w_b_rd    = w_b_req && bus.iWrnB;
   assign w_a_wr    = w_a_req && !bus.iWrnA && w_a_in;
   assign w_b_wr    = w_b_req && !bus.iWrnB && w_b_in;
   assign w_a_rdata = w_a_in ? r_mem[bus.iAddrA] : '0;
   assign w_b_rdata = w_b_in ? r_mem[bus.iAddrB] : '0;

   // Control FSM: one zeroing pass over the array after reset, then serve requests
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else if (r_state == S_INIT) begin
         if (r_cnt == ADDR_WIDTH'(SRAM_DEPTH - 1)) begin
            r_state <= S_READY;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
         end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
         end
      end
   end

   // Storage: sweep zeroes one word per cycle; byte writes apply B first so A wins shared bytes
   always_ff @(posedge iClk) begin
      if (r_state == S_INIT) begin
         if (!iRst) begin
            r_mem[r_cnt] <= '0;
         end
      end else begin
         for (int j = 0; j < NBYTE; j++) begin
            if (w_b_wr && bus.iBeB[j]) begin
               r_mem[bus.iAddrB][j*8 +: 8] <= bus.iWrDtB[j*8 +: 8];
            end
            if (w_a_wr && bus.iBeA[j]) begin
               r_mem[bus.iAddrA][j*8 +: 8] <= bus.iWrDtA[j*8 +: 8];
            end
         end
      end
   end

   // First read stage samples pre-write data; data registers hold between reads
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_vld1_a <= 1'b0;
         r_vld1_b <= 1'b0;
         r_dt1_a  <= '0;
         r_dt1_b  <= '0;
         r_err    <= 2'b00;
      end else begin
         r_vld1_a <= w_a_rd;
         r_vld1_b <= w_b_rd;
         if (w_a_rd) r_dt1_a <= w_a_rdata;
         if (w_b_rd) r_dt1_b <= w_b_rdata;
         r_err    <= {w_b_req && !w_b_in, w_a_req && !w_a_in};
      end
   end

   assign bus.oBusy    = r_busy;
   assign bus.oAddrErr = r_err;

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  r_vld2_a, r_vld2_b;
         logic [DATA_WIDTH-1:0] r_dt2_a, r_dt2_b;

         // Extra output stage; advances every cycle so back-to-back reads stream
         always_ff @(posedge iClk) begin
            if (iRst) begin
               r_vld2_a <= 1'b0;
               r_vld2_b <= 1'b0;
               r_dt2_a  <= '0;
               r_dt2_b  <= '0;
            end else begin
               r_vld2_a <= r_vld1_a;
               r_vld2_b <= r_vld1_b;
               if (r_vld1_a) r_dt2_a <= r_dt1_a;
               if (r_vld1_b) r_dt2_b <= r_dt1_b;
            end
         end

         assign bus.oRdVldA = r_vld2_a;
         assign bus.oRdVldB = r_vld2_b;
         assign bus.oRdDtA  = r_dt2_a;
         assign bus.oRdDtB  = r_dt2_b;
      end else begin : g_lat1
         assign bus.oRdVldA = r_vld1_a;
         assign bus.oRdVldB = r_vld1_b;
         assign bus.oRdDtA  = r_dt1_a;
         assign bus.oRdDtB  = r_dt1_b;
      end
   endgenerate
endmodule

// File: tb/tb_dp_sram_be.sv
// tb/tb_dp_sram_be.sv - two-configuration bench for dp_sram_be against a word-array model
module tb_dp_sram_be;
   localparam int DEP [2] = '{16, 10};
   localparam int LAT [2] = '{1, 2};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        csn_a = 1'b1, wrn_a = 1'b1, csn_b = 1'b1, wrn_b = 1'b1;
   logic [3:0]  addr_a = '0, addr_b = '0, be_a = '0, be_b = '0;
   logic [31:0] wd_a = '0, wd_b = '0;

   dp_sram_be_if #(.SRAM_DEPTH(16), .DATA_WIDTH(32)) if0 ();
   dp_sram_be_if #(.SRAM_DEPTH(10), .DATA_WIDTH(32)) if1 ();

   assign if0.iCsnA = csn_a;  assign if1.iCsnA = csn_a;
   assign if0.iWrnA = wrn_a;  assign if1.iWrnA = wrn_a;
   assign if0.iAddrA = addr_a; assign if1.iAddrA = addr_a;
   assign if0.iWrDtA = wd_a;  assign if1.iWrDtA = wd_a;
   assign if0.iBeA = be_a;    assign if1.iBeA = be_a;
   assign if0.iCsnB = csn_b;  assign if1.iCsnB = csn_b;
   assign if0.iWrnB = wrn_b;  assign if1.iWrnB = wrn_b;
   assign if0.iAddrB = addr_b; assign if1.iAddrB = addr_b;
   assign if0.iWrDtB = wd_b;  assign if1.iWrDtB = wd_b;
   assign if0.iBeB = be_b;    assign if1.iBeB = be_b;

   dp_sram_be #(.SRAM_DEPTH(16), .DATA_WIDTH(32), .RD_LATENCY(1)) u_dut0 (
      .iClk(clk), .iRst(rst), .bus(if0.slave));
   dp_sram_be #(.SRAM_DEPTH(10), .DATA_WIDTH(32), .RD_LATENCY(2)) u_dut1 (
      .iClk(clk), .iRst(rst), .bus(if1.slave));

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] mm [2][16];
   int          busy_left [2];
   logic [31:0] exp_dt [2][2];
   logic        exp_vld [2][2];
   logic [1:0]  exp_err [2];
   logic        pend_v [2][2][4];
   logic [31:0] pend_d [2][2][4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: each edge either resets, sweeps one word, or serves both ports read-first
   task automatic model_edge();
      logic        cs [2], wr [2];
      logic [3:0]  ad [2], be [2];
      logic [31:0] wd [2];
      int          slot;
      cyc++;
      cs[0] = csn_a; wr[0] = wrn_a; ad[0] = addr_a; be[0] = be_a; wd[0] = wd_a;
      cs[1] = csn_b; wr[1] = wrn_b; ad[1] = addr_b; be[1] = be_b; wd[1] = wd_b;
      for (int d = 0; d < 2; d++) begin
         exp_err[d] = 2'b00;
         for (int p = 0; p < 2; p++) exp_vld[d][p] = 1'b0;
         if (rst) begin
            busy_left[d] = DEP[d];
            for (int p = 0; p < 2; p++) begin
               exp_dt[d][p] = '0;
               for (int s = 0; s < 4; s++) pend_v[d][p][s] = 1'b0;
            end
         end else begin
            if (busy_left[d] > 0) begin
               mm[d][DEP[d] - busy_left[d]] = '0;
               busy_left[d]--;
            end else begin
               for (int p = 0; p < 2; p++) begin
                  if (!cs[p] && wr[p]) begin
                     slot = (cyc + LAT[d] - 1) % 4;
                     pend_v[d][p][slot] = 1'b1;
                     pend_d[d][p][slot] = (ad[p] < DEP[d]) ? mm[d][ad[p]] : 32'h0;
                  end
                  if (!cs[p] && ad[p] >= DEP[d]) exp_err[d][p] = 1'b1;
               end
               for (int p = 1; p >= 0; p--) begin
                  if (!cs[p] && !wr[p] && ad[p] < DEP[d]) begin
                     for (int k = 0; k < 4; k++)
                        if (be[p][k]) mm[d][ad[p]][k*8 +: 8] = wd[p][k*8 +: 8];
                  end
               end
            end
            slot = cyc % 4;
            for (int p = 0; p < 2; p++) begin
               if (pend_v[d][p][slot]) begin
                  exp_vld[d][p] = 1'b1;
                  exp_dt[d][p]  = pend_d[d][p][slot];
                  pend_v[d][p][slot] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic compare();
      logic [31:0] od [2][2];
      logic        ov [2][2];
      logic [1:0]  oe [2];
      logic        ob [2];
      od[0][0] = if0.oRdDtA; od[0][1] = if0.oRdDtB; ov[0][0] = if0.oRdVldA; ov[0][1] = if0.oRdVldB;
      od[1][0] = if1.oRdDtA; od[1][1] = if1.oRdDtB; ov[1][0] = if1.oRdVldA; ov[1][1] = if1.oRdVldB;
      oe[0] = if0.oAddrErr; ob[0] = if0.oBusy;
      oe[1] = if1.oAddrErr; ob[1] = if1.oBusy;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("busy d%0d c%0d", d, cyc), 32'(ob[d]), 32'(busy_left[d] > 0));
         check($sformatf("addr_err d%0d c%0d", d, cyc), 32'(oe[d]), 32'(exp_err[d]));
         for (int p = 0; p < 2; p++) begin
            check($sformatf("rd_vld d%0d p%0d c%0d", d, p, cyc), 32'(ov[d][p]), 32'(exp_vld[d][p]));
            check($sformatf("rd_dt d%0d p%0d c%0d", d, p, cyc), od[d][p], exp_dt[d][p]);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic set_a(input logic c, input logic w, input logic [3:0] a, input logic [31:0] dt, input logic [3:0] b);
      csn_a = c; wrn_a = w; addr_a = a; wd_a = dt; be_a = b;
   endtask

   task automatic set_b(input logic c, input logic w, input logic [3:0] a, input logic [31:0] dt, input logic [3:0] b);
      csn_b = c; wrn_b = w; addr_b = a; wd_b = dt; be_b = b;
   endtask

   task automatic idle();
      set_a(1'b1, 1'b1, 4'h0, 32'h0, 4'h0);
      set_b(1'b1, 1'b1, 4'h0, 32'h0, 4'h0);
   endtask

   task automatic rand_req();
      set_a(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom));
      set_b(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom));
      if ($urandom_range(0, 3) == 0) addr_b = addr_a;
   endtask

   task automatic count_busy(input string tag);
      int bc0, bc1;
      bc0 = 0; bc1 = 0;
      for (int i = 0; i < 40; i++) begin
         if (if0.oBusy === 1'b1) bc0++;
         if (if1.oBusy === 1'b1) bc1++;
         if (if0.oBusy !== 1'b1 && if1.oBusy !== 1'b1) break;
         step();
      end
      check({tag, " busy_cycles d0"}, 32'(bc0), 32'd16);
      check({tag, " busy_cycles d1"}, 32'(bc1), 32'd10);
   endtask

   initial begin
      int pulses;
      idle();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      count_busy("init");

      for (int i = 0; i < 16; i++) begin
         set_a(1'b0, 1'b1, 4'(i), 32'h0, 4'h0);
         set_b(1'b0, 1'b1, 4'(15 - i), 32'h0, 4'h0);
         step();
      end
      idle(); step(); step();

      set_a(1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 4'b1111); step();
      set_a(1'b0, 1'b0, 4'd3, 32'h000000AA, 4'b0001); step();
      idle(); set_b(1'b0, 1'b1, 4'd3, 32'h0, 4'h0); step();
      check("byte_merge d0 data", if0.oRdDtB, 32'hDEADBEAA);
      check("byte_merge d0 vld", 32'(if0.oRdVldB), 32'd1);
      idle(); step();
      check("byte_merge d1 data", if1.oRdDtB, 32'hDEADBEAA);
      check("byte_merge d1 vld", 32'(if1.oRdVldB), 32'd1);

      set_a(1'b0, 1'b0, 4'd5, 32'h11111111, 4'hF); step();
      set_a(1'b0, 1'b0, 4'd5, 32'h22222222, 4'hF); set_b(1'b0, 1'b1, 4'd5, 32'h0, 4'h0); step();
      check("read_first d0", if0.oRdDtB, 32'h11111111);
      idle(); set_b(1'b0, 1'b1, 4'd5, 32'h0, 4'h0); step();
      check("read_first d1", if1.oRdDtB, 32'h11111111);
      idle(); step();
      check("after_write d1", if1.oRdDtB, 32'h22222222);

      set_a(1'b0, 1'b0, 4'd7, 32'hAAAAAAAA, 4'b0011);
      set_b(1'b0, 1'b0, 4'd7, 32'hBBBBBBBB, 4'b0110); step();
      idle(); set_a(1'b0, 1'b1, 4'd7, 32'h0, 4'h0); step();
      check("dual_write d0", if0.oRdDtA, 32'h00BBAAAA);
      idle(); step();
      check("dual_write d1", if1.oRdDtA, 32'h00BBAAAA);

      set_a(1'b0, 1'b1, 4'd12, 32'h0, 4'h0);
      set_b(1'b0, 1'b0, 4'd15, 32'h12345678, 4'hF); step();
      check("oor addr_err d1", 32'(if1.oAddrErr), 32'd3);
      idle(); step();
      check("oor addr_err clear d1", 32'(if1.oAddrErr), 32'd0);
      check("oor rd zero d1", if1.oRdDtA, 32'h0);
      check("oor rd vld d1", 32'(if1.oRdVldA), 32'd1);

      for (int i = 0; i < 300; i++) begin
         rand_req();
         step();
      end

      for (int i = 0; i < 4; i++) begin
         set_a(1'b0, 1'b1, 4'(i), 32'h0, 4'h0);
         set_b(1'b0, 1'b1, 4'(i + 4), 32'h0, 4'h0);
         step();
      end
      rst = 1'b1; step();
      pulses = 0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (if1.oRdVldA === 1'b1 || if1.oRdVldB === 1'b1) pulses++;
         rand_req();
         step();
      end
      check("no vld after reset d1", 32'(pulses), 32'd0);
      rst = 1'b1; step(); step();
      rst = 1'b0; idle();
      count_busy("restart");

      for (int i = 0; i < 16; i++) begin
         set_a(1'b0, 1'b1, 4'(i), 32'h0, 4'h0);
         set_b(1'b0, 1'b1, 4'(i), 32'h0, 4'h0);
         step();
      end
      for (int i = 0; i < 100; i++) begin
         rand_req();
         step();
      end
      idle(); step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
